// File: rtl/cnn_layer_ctrl.sv
// Layer sequencer for the CNN accelerator: latches one layer command, then walks
// weight load, image stream and optional FC phases, reporting done/err.
module cnn_layer_ctrl #(
    parameter int NUM_FILT = 32,
    parameter int FILT_W   = 6,
    parameter int DIM_W    = 5,
    parameter int CNT_W    = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [2:0]          op_i,
    input  logic [FILT_W-1:0]   num_filt_i,
    input  logic [DIM_W-1:0]    wdim_i,
    input  logic [CNT_W-1:0]    first_out_i,
    input  logic [CNT_W-1:0]    pu_stop_i,
    input  logic [CNT_W-1:0]    layer_len_i,
    input  logic                w_valid_i,
    output logic                w_ready_o,
    input  logic                conv_finish_i,
    input  logic                fc_finish_i,
    output logic [NUM_FILT-1:0] weight_en_o,
    output logic                pu_en_o,
    output logic                fifo_en_o,
    output logic                conv_en_o,
    output logic                pool_en_o,
    output logic                fc_en_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [FILT_W-1:0]   filt_idx_o,
    output logic [CNT_W-1:0]    stream_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_FC,
        S_DONE
    } state_t;

    localparam logic [2:0]        OP_NOP       = 3'b000;
    localparam logic [2:0]        OP_CONV      = 3'b001;
    localparam logic [2:0]        OP_CONV_POOL = 3'b010;
    localparam logic [2:0]        OP_FC        = 3'b011;
    localparam logic [2:0]        OP_CPF       = 3'b110;
    localparam logic [2:0]        OP_OUT       = 3'b111;
    localparam logic [FILT_W:0]   LP_NF_MAX    = (FILT_W+1)'(NUM_FILT);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_set_err;

    logic [2:0]          r_op;
    logic [FILT_W-1:0]   r_nf;
    logic [DIM_W-1:0]    r_wdim;
    logic [CNT_W-1:0]    r_first_out;
    logic [CNT_W-1:0]    r_pu_stop;
    logic [CNT_W-1:0]    r_len;

    logic [FILT_W-1:0]   r_filt_idx;
    logic [DIM_W-1:0]    r_elem;
    logic [CNT_W-1:0]    r_stream_cnt;
    logic                r_err;

    logic                w_start_acc;
    logic                w_cfg_bad;
    logic                w_load_active;
    logic                w_beat;
    logic                w_last_elem;
    logic                w_last_filt;
    logic [CNT_W-1:0]    w_len_last;
    logic                w_stream_last;
    logic                w_pool_op;

    assign w_start_acc   = (r_state == S_IDLE) && start_i;
    // Conv-class commands are validated from the latched fields in the first LOAD_W cycle.
    assign w_cfg_bad     = (r_nf == '0) || ({1'b0, r_nf} > LP_NF_MAX) || (r_wdim == '0);
    assign w_load_active = (r_state == S_LOAD_W) && !w_cfg_bad;
    assign w_beat        = w_load_active && w_valid_i;
    assign w_last_elem   = (r_elem == (r_wdim - DIM_W'(1)));
    assign w_last_filt   = (r_filt_idx == (r_nf - FILT_W'(1)));
    assign w_len_last    = (r_len == '0) ? '0 : (r_len - CNT_W'(1));
    assign w_stream_last = (r_stream_cnt == w_len_last);
    assign w_pool_op     = (r_op == OP_CONV_POOL) || (r_op == OP_CPF);

    always_comb begin
        w_next_state = r_state;
        w_set_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    case (op_i)
                        OP_CONV, OP_CONV_POOL, OP_CPF: w_next_state = S_LOAD_W;
                        OP_FC:                         w_next_state = S_FC;
                        OP_NOP, OP_OUT:                w_next_state = S_DONE;
                        default: begin
                            w_next_state = S_DONE;
                            w_set_err    = 1'b1;
                        end
                    endcase
                end
            end
            S_LOAD_W: begin
                if (w_cfg_bad) begin
                    w_next_state = S_DONE;
                    w_set_err    = 1'b1;
                end else if (w_beat && w_last_elem && w_last_filt) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_stream_last) begin
                    w_next_state = (r_op == OP_CPF) ? S_FC : S_DONE;
                end
            end
            S_FC: begin
                if (fc_finish_i) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_filt_idx   <= '0;
            r_elem       <= '0;
            r_stream_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_start_acc) begin
                r_err <= w_set_err;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_LOAD_W: begin
                    if (w_beat) begin
                        if (w_last_elem) begin
                            r_elem <= '0;
                            if (!w_last_filt) begin
                                r_filt_idx <= r_filt_idx + FILT_W'(1);
                            end
                        end else begin
                            r_elem <= r_elem + DIM_W'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (!w_stream_last) begin
                        r_stream_cnt <= r_stream_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_filt_idx   <= '0;
                    r_elem       <= '0;
                    r_stream_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Command fields are pure data: captured on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (w_start_acc) begin
            r_op        <= op_i;
            r_nf        <= num_filt_i;
            r_wdim      <= wdim_i;
            r_first_out <= first_out_i;
            r_pu_stop   <= pu_stop_i;
            r_len       <= layer_len_i;
        end
    end

    assign w_ready_o    = w_load_active;
    assign weight_en_o  = w_load_active ? (NUM_FILT'(1) << r_filt_idx) : '0;
    assign pu_en_o      = (r_state == S_STREAM) && (r_stream_cnt < r_pu_stop);
    assign conv_en_o    = (r_state == S_STREAM) && (r_stream_cnt >= r_first_out);
    assign fifo_en_o    = conv_en_o;
    assign pool_en_o    = (r_state == S_STREAM) && w_pool_op && conv_finish_i;
    assign fc_en_o      = (r_state == S_FC);
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign err_o        = r_err;
    assign filt_idx_o   = r_filt_idx;
    assign stream_cnt_o = r_stream_cnt;

endmodule

// File: tb/tb_cnn_layer_ctrl.sv
// Directed bench for cnn_layer_ctrl: load/stream/FC sequencing, pooling gating,
// error handling, reset mid-run and start-while-busy.
module tb_cnn_layer_ctrl;

    localparam int NUM_FILT = 32;
    localparam int FILT_W   = 6;
    localparam int DIM_W    = 5;
    localparam int CNT_W    = 11;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_i;
    logic [2:0]          op_i;
    logic [FILT_W-1:0]   num_filt_i;
    logic [DIM_W-1:0]    wdim_i;
    logic [CNT_W-1:0]    first_out_i;
    logic [CNT_W-1:0]    pu_stop_i;
    logic [CNT_W-1:0]    layer_len_i;
    logic                w_valid_i;
    logic                w_ready_o;
    logic                conv_finish_i;
    logic                fc_finish_i;
    logic [NUM_FILT-1:0] weight_en_o;
    logic                pu_en_o, fifo_en_o, conv_en_o, pool_en_o, fc_en_o;
    logic                busy_o, done_o, err_o;
    logic [FILT_W-1:0]   filt_idx_o;
    logic [CNT_W-1:0]    stream_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_start;

    cnn_layer_ctrl #(
        .NUM_FILT(NUM_FILT), .FILT_W(FILT_W), .DIM_W(DIM_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .num_filt_i(num_filt_i), .wdim_i(wdim_i), .first_out_i(first_out_i),
        .pu_stop_i(pu_stop_i), .layer_len_i(layer_len_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .conv_finish_i(conv_finish_i), .fc_finish_i(fc_finish_i),
        .weight_en_o(weight_en_o), .pu_en_o(pu_en_o), .fifo_en_o(fifo_en_o),
        .conv_en_o(conv_en_o), .pool_en_o(pool_en_o), .fc_en_o(fc_en_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .filt_idx_o(filt_idx_o), .stream_cnt_o(stream_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] op, input int nf, input int wd,
                       input int fo, input int ps, input int ll);
        op_i        = op;
        num_filt_i  = FILT_W'(nf);
        wdim_i      = DIM_W'(wd);
        first_out_i = CNT_W'(fo);
        pu_stop_i   = CNT_W'(ps);
        layer_len_i = CNT_W'(ll);
        start_i     = 1'b1;
        t_start     = cyc;
        step();
        start_i     = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_wen"}, 64'(weight_en_o), 64'd0);
        chk({tag, "_en"}, 64'({w_ready_o, pu_en_o, fifo_en_o, conv_en_o, pool_en_o, fc_en_o}), 64'd0);
        chk({tag, "_cnt"}, 64'({filt_idx_o, stream_cnt_o}), 64'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start_i = 1'b0; op_i = '0; num_filt_i = '0; wdim_i = '0;
        first_out_i = '0; pu_stop_i = '0; layer_len_i = '0;
        w_valid_i = 1'b0; conv_finish_i = 1'b0; fc_finish_i = 1'b0;
        step(); step();
        chk_idle_outputs("reset");
        chk("reset_err", 64'(err_o), 64'd0);
        rst = 1'b0;
        step();

        // Conv, continuous weight stream
        w_valid_i = 1'b1;
        cmd(3'b001, 2, 3, 4, 8, 10);
        for (int i = 0; i < 6; i++) begin
            chk("t1_wen", 64'(weight_en_o), (i < 3) ? 64'h1 : 64'h2);
            chk("t1_wready", 64'(w_ready_o), 64'd1);
            step();
        end
        for (int s = 0; s < 10; s++) begin
            chk("t1_scnt", 64'(stream_cnt_o), 64'(s));
            chk("t1_pu", 64'(pu_en_o), 64'(s < 8));
            chk("t1_conv", 64'(conv_en_o), 64'(s >= 4));
            chk("t1_fifo", 64'(fifo_en_o), 64'(s >= 4));
            chk("t1_wen_s", 64'(weight_en_o), 64'd0);
            chk("t1_done_early", 64'(done_o), 64'd0);
            step();
        end
        chk("t1_done", 64'(done_o), 64'd1);
        chk("t1_latency", 64'(cyc - t_start), 64'd17);
        chk("t1_err", 64'(err_o), 64'd0);
        step();
        chk("t1_done_pulse", 64'({busy_o, done_o}), 64'd0);

        // Same command, weight beats only on every other cycle
        w_valid_i = 1'b0;
        cmd(3'b001, 2, 3, 4, 8, 10);
        for (int i = 0; i < 12; i++) begin
            w_valid_i = (i % 2 == 1);
            #1;
            chk("t2_wen", 64'(weight_en_o), 64'(1) << ((i / 2) / 3));
            chk("t2_fidx", 64'(filt_idx_o), 64'((i / 2) / 3));
            chk("t2_wready", 64'(w_ready_o), 64'd1);
            step();
        end
        w_valid_i = 1'b0;
        chk("t2_stream_entry", 64'({w_ready_o, stream_cnt_o}), 64'd0);
        chk("t2_stream_pu", 64'(pu_en_o), 64'd1);
        seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (!seen) begin
                if (done_o) seen = 1'b1;
                else step();
            end
        end
        chk("t2_done_seen", 64'(seen), 64'd1);
        step();

        // Pooling gate follows conv_finish_i only for pooling ops in STREAM
        w_valid_i = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            cmd((pass == 0) ? 3'b010 : 3'b001, 1, 1, 0, 2, 10);
            conv_finish_i = 1'b1;
            #1;
            chk("t3_pool_load", 64'(pool_en_o), 64'd0);
            conv_finish_i = 1'b0;
            step();
            for (int s = 0; s < 10; s++) begin
                conv_finish_i = (s == 6);
                #1;
                chk("t3_scnt", 64'(stream_cnt_o), 64'(s));
                chk("t3_pool", 64'(pool_en_o), (pass == 0) ? 64'(s == 6) : 64'd0);
                step();
            end
            conv_finish_i = 1'b0;
            chk("t3_done", 64'(done_o), 64'd1);
            step();
        end

        // Conv+pool+FC, first_out beyond layer length
        cmd(3'b110, 1, 1, 5, 1, 2);
        step();
        chk("t4_s0", 64'({pu_en_o, conv_en_o, fifo_en_o}), 64'b100);
        step();
        chk("t4_s1", 64'({pu_en_o, conv_en_o, fifo_en_o}), 64'b000);
        step();
        for (int i = 0; i < 5; i++) begin
            fc_finish_i = (i == 4);
            chk("t4_fc_en", 64'(fc_en_o), 64'd1);
            chk("t4_fc_done", 64'(done_o), 64'd0);
            step();
        end
        fc_finish_i = 1'b0;
        chk("t4_done", 64'({fc_en_o, done_o}), 64'b01);
        step();

        // layer_len = 0 behaves as a single stream cycle
        cmd(3'b001, 1, 1, 0, 1, 0);
        step();
        chk("t4b_stream", 64'({stream_cnt_o, conv_en_o}), 64'd1);
        step();
        chk("t4b_done", 64'(done_o), 64'd1);
        step();

        // Error handling
        cmd(3'b101, 1, 1, 0, 1, 1);
        chk("t5_illegal_op", 64'({done_o, err_o}), 64'b11);
        step();
        chk("t5_sticky", 64'({busy_o, done_o, err_o}), 64'b001);
        cmd(3'b001, 0, 3, 0, 1, 1);
        chk("t5_err_clear", 64'({done_o, err_o, w_ready_o}), 64'b000);
        step();
        chk("t5_nf0", 64'({done_o, err_o}), 64'b11);
        chk("t5_nf0_latency", 64'(cyc - t_start), 64'd2);
        step();
        cmd(3'b010, 33, 1, 0, 1, 1);
        step();
        chk("t5_nf_over", 64'({done_o, err_o}), 64'b11);
        step();
        cmd(3'b000, 1, 1, 0, 1, 1);
        chk("t5_nop_clears", 64'({done_o, err_o}), 64'b10);
        step();

        // Start while busy is ignored; reset mid-stream aborts with no done
        cmd(3'b001, 1, 1, 0, 8, 10);
        step();
        step();
        start_i = 1'b1; op_i = 3'b011;
        step();
        start_i = 1'b0;
        chk("t6_ignore_start", 64'({stream_cnt_o, fc_en_o}), 64'({11'd2, 1'b0}));
        step();
        chk("t6_s3", 64'(stream_cnt_o), 64'd3);
        rst = 1'b1;
        step();
        chk_idle_outputs("t6_rst");
        rst = 1'b0;
        step();
        chk("t6_no_done", 64'({busy_o, done_o}), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
